// File: rtl/sram_controller_param.sv
// Parametrised single-port bridge from the MEM stage to an external asynchronous SRAM.
// A CPU word is moved as BEATS sequential SRAM accesses; every SRAM-facing output is registered.
module sram_controller_param #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned SRAM_DQ_WIDTH   = 16,
  parameter int unsigned SRAM_ADDR_WIDTH = 18,
  parameter int unsigned BASE_ADDR       = 1024,
  parameter int unsigned WAIT_CYCLES     = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wrEn,
  input  logic                         rdEn,
  input  logic [31:0]                  address,
  input  logic [DATA_WIDTH-1:0]        writeData,
  input  logic [DATA_WIDTH/8-1:0]      byteEn,
  output logic [DATA_WIDTH-1:0]        readData,
  output logic                         ready,
  output logic                         err,
  inout  wire  [SRAM_DQ_WIDTH-1:0]     SRAM_DQ,
  output logic [SRAM_ADDR_WIDTH-1:0]   SRAM_ADDR,
  output logic                         SRAM_WE_N,
  output logic                         SRAM_CE_N,
  output logic                         SRAM_OE_N,
  output logic [SRAM_DQ_WIDTH/8-1:0]   SRAM_BE_N
);

  localparam int unsigned BEATS  = DATA_WIDTH / SRAM_DQ_WIDTH;
  localparam int unsigned LANES  = SRAM_DQ_WIDTH / 8;
  localparam int unsigned BW     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned WW     = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam int unsigned IDX_SH = $clog2(DATA_WIDTH / 8);
  localparam logic [63:0] LIMIT  = (64'd1 << SRAM_ADDR_WIDTH) - 64'(BEATS);

  typedef enum logic [2:0] {IDLE, WRITE, READ, STALL, DONE} state_t;

  state_t                       state_q, state_d;
  logic [BW-1:0]                beat_q, beat_d, cap;
  logic                         tail_q, tail_d;
  logic [WW-1:0]                wait_q, wait_d;
  logic                         wr_q, wr_d;
  logic [31:0]                  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]        wdata_q, wdata_d;
  logic [DATA_WIDTH/8-1:0]      be_q, be_d;
  logic [DATA_WIDTH-1:0]        shadow_q, shadow_d;
  logic [DATA_WIDTH-1:0]        rdata_q, rdata_d;
  logic                         err_q, err_d;
  logic [SRAM_DQ_WIDTH-1:0]     dq_in_q;
  logic [SRAM_ADDR_WIDTH-1:0]   sa_q, sa_d;
  logic                         we_n_q, we_n_d, ce_n_q, ce_n_d, oe_n_q, oe_n_d;
  logic [LANES-1:0]             ben_q, ben_d;
  logic                         dq_oe_q, dq_oe_d;
  logic [SRAM_DQ_WIDTH-1:0]     dq_out_q, dq_out_d;
  logic [31:0]                  req_idx, lat_idx;
  logic                         req_bad;

  always_comb begin
    req_idx = (address - 32'(BASE_ADDR)) >> IDX_SH;
    req_bad = (address < 32'(BASE_ADDR)) || ((64'(req_idx) * 64'(BEATS)) > LIMIT);
  end

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    tail_d   = 1'b0;
    wait_d   = wait_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    shadow_d = shadow_q;
    rdata_d  = rdata_q;
    err_d    = 1'b0;
    cap      = tail_q ? BW'(BEATS - 1) : beat_q - 1'b1;
    case (state_q)
      IDLE: begin
        beat_d = '0;
        wait_d = '0;
        if (wrEn || rdEn) begin
          wr_d    = wrEn;
          addr_d  = address;
          wdata_d = writeData;
          be_d    = byteEn;
          if (req_bad) begin
            state_d = DONE;
            err_d   = 1'b1;
          end else begin
            state_d = wrEn ? WRITE : READ;
          end
        end
      end
      WRITE: begin
        if (32'(beat_q) == BEATS - 1) begin
          beat_d  = '0;
          state_d = (WAIT_CYCLES == 0) ? DONE : STALL;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      READ: begin
        // DQ passes through an input flop, so the slice landing now belongs to the previous beat.
        if (tail_q || beat_q != '0)
          shadow_d[cap*SRAM_DQ_WIDTH +: SRAM_DQ_WIDTH] = dq_in_q;
        if (tail_q)
          state_d = (WAIT_CYCLES == 0) ? DONE : STALL;
        else if (32'(beat_q) == BEATS - 1)
          tail_d = 1'b1;
        else
          beat_d = beat_q + 1'b1;
      end
      STALL: begin
        if (32'(wait_q) == WAIT_CYCLES - 1) state_d = DONE;
        else                                wait_d  = wait_q + 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d == DONE && !wr_q && (state_q == READ || state_q == STALL))
      rdata_d = shadow_d;
  end

  // SRAM pins are computed from the next state so the registered strobes line up with it.
  always_comb begin
    lat_idx  = (addr_d - 32'(BASE_ADDR)) >> IDX_SH;
    sa_d     = sa_q;
    we_n_d   = 1'b1;
    ce_n_d   = 1'b1;
    oe_n_d   = 1'b1;
    ben_d    = '1;
    dq_oe_d  = 1'b0;
    dq_out_d = dq_out_q;
    if (state_d == WRITE) begin
      ce_n_d   = 1'b0;
      we_n_d   = 1'b0;
      dq_oe_d  = 1'b1;
      sa_d     = SRAM_ADDR_WIDTH'(lat_idx * BEATS + 32'(beat_d));
      dq_out_d = wdata_d[beat_d*SRAM_DQ_WIDTH +: SRAM_DQ_WIDTH];
      ben_d    = ~be_d[beat_d*LANES +: LANES];
    end else if (state_d == READ) begin
      ce_n_d = 1'b0;
      oe_n_d = 1'b0;
      ben_d  = '0;
      sa_d   = SRAM_ADDR_WIDTH'(lat_idx * BEATS + 32'(beat_d));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      tail_q   <= 1'b0;
      wait_q   <= '0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      shadow_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      dq_in_q  <= '0;
      sa_q     <= '0;
      we_n_q   <= 1'b1;
      ce_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      ben_q    <= '1;
      dq_oe_q  <= 1'b0;
      dq_out_q <= '0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      tail_q   <= tail_d;
      wait_q   <= wait_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      shadow_q <= shadow_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      dq_in_q  <= SRAM_DQ;
      sa_q     <= sa_d;
      we_n_q   <= we_n_d;
      ce_n_q   <= ce_n_d;
      oe_n_q   <= oe_n_d;
      ben_q    <= ben_d;
      dq_oe_q  <= dq_oe_d;
      dq_out_q <= dq_out_d;
    end
  end

  assign ready     = (state_q == IDLE && !wrEn && !rdEn) || (state_q == DONE);
  assign err       = err_q;
  assign readData  = rdata_q;
  assign SRAM_ADDR = sa_q;
  assign SRAM_WE_N = we_n_q;
  assign SRAM_CE_N = ce_n_q;
  assign SRAM_OE_N = oe_n_q;
  assign SRAM_BE_N = ben_q;
  assign SRAM_DQ   = dq_oe_q ? dq_out_q : 'z;

endmodule

// File: tb/tb_sram_controller_param.sv
// Bench for sram_controller_param: default 32/16-bit instance plus a 64-bit, zero-wait instance,
// each attached to a behavioural asynchronous SRAM and checked against a word-level memory model.
module tb_sram_controller_param;

  localparam int BASE   = 1024;
  localparam int BEATS_A = 2, WAIT_A = 4;
  localparam int BEATS_B = 4, WAIT_B = 0;
  localparam int LAT_WR_A = BEATS_A + WAIT_A + 1;
  localparam int LAT_RD_A = BEATS_A + 1 + WAIT_A + 1;
  localparam int LAT_WR_B = BEATS_B + WAIT_B + 1;
  localparam int LAT_RD_B = BEATS_B + 1 + WAIT_B + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        a_wr, a_rd, a_ready, a_err, a_we_n, a_ce_n, a_oe_n;
  logic [31:0] a_adr, a_wd, a_rdata;
  logic [3:0]  a_be;
  logic [1:0]  a_ben;
  logic [17:0] a_sa;
  wire  [15:0] a_dq;

  logic        b_wr, b_rd, b_ready, b_err, b_we_n, b_ce_n, b_oe_n;
  logic [31:0] b_adr;
  logic [63:0] b_wd, b_rdata;
  logic [7:0]  b_be;
  logic [1:0]  b_ben;
  logic [17:0] b_sa;
  wire  [15:0] b_dq;

  sram_controller_param dut_a (
    .clk(clk), .rst(rst), .wrEn(a_wr), .rdEn(a_rd), .address(a_adr), .writeData(a_wd),
    .byteEn(a_be), .readData(a_rdata), .ready(a_ready), .err(a_err), .SRAM_DQ(a_dq),
    .SRAM_ADDR(a_sa), .SRAM_WE_N(a_we_n), .SRAM_CE_N(a_ce_n), .SRAM_OE_N(a_oe_n), .SRAM_BE_N(a_ben)
  );

  sram_controller_param #(.DATA_WIDTH(64), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .wrEn(b_wr), .rdEn(b_rd), .address(b_adr), .writeData(b_wd),
    .byteEn(b_be), .readData(b_rdata), .ready(b_ready), .err(b_err), .SRAM_DQ(b_dq),
    .SRAM_ADDR(b_sa), .SRAM_WE_N(b_we_n), .SRAM_CE_N(b_ce_n), .SRAM_OE_N(b_oe_n), .SRAM_BE_N(b_ben)
  );

  // Asynchronous SRAM models: combinational read, lane-masked write while CE_N and WE_N are low.
  logic [15:0] mem_a [0:262143];
  logic [15:0] mem_b [0:262143];
  assign a_dq = (!a_ce_n && !a_oe_n && a_we_n) ? mem_a[a_sa] : 16'bz;
  assign b_dq = (!b_ce_n && !b_oe_n && b_we_n) ? mem_b[b_sa] : 16'bz;
  always @(negedge clk) begin
    if (!a_ce_n && !a_we_n) begin
      if (!a_ben[0]) mem_a[a_sa][7:0]  <= a_dq[7:0];
      if (!a_ben[1]) mem_a[a_sa][15:8] <= a_dq[15:8];
    end
    if (!b_ce_n && !b_we_n) begin
      if (!b_ben[0]) mem_b[b_sa][7:0]  <= b_dq[7:0];
      if (!b_ben[1]) mem_b[b_sa][15:8] <= b_dq[15:8];
    end
  end

  int n_checks = 0, n_fail = 0;
  logic [31:0] ref_a [int];
  int lat, ce_cyc, we_cyc, clash;
  logic got_err;
  logic [17:0] wq_addr [$];
  logic [15:0] wq_dq [$];
  logic [1:0]  wq_ben [$];

  function automatic logic [31:0] merge32(logic [31:0] o, logic [31:0] n, logic [3:0] be);
    for (int i = 0; i < 4; i++) if (be[i]) o[i*8 +: 8] = n[i*8 +: 8];
    return o;
  endfunction

  function automatic logic [31:0] get_a(int idx);
    return ref_a.exists(idx) ? ref_a[idx] : 32'h0;
  endfunction

  // Presents one request, scrambles the inputs after acceptance, then watches the bus until ready.
  task automatic run_a(input logic w, input logic r, input logic [31:0] adr,
                       input logic [31:0] wd, input logic [3:0] be);
    @(negedge clk);
    a_wr = w; a_rd = r; a_adr = adr; a_wd = wd; a_be = be;
    @(posedge clk); #1;
    a_wr = 1'b0; a_rd = 1'b0; a_adr = $urandom; a_wd = $urandom; a_be = 4'($urandom);
    lat = 0; ce_cyc = 0; we_cyc = 0; clash = 0;
    wq_addr.delete(); wq_dq.delete(); wq_ben.delete();
    do begin
      @(negedge clk); lat++;
      if (!a_ce_n) ce_cyc++;
      if (!a_we_n) begin
        we_cyc++; wq_addr.push_back(a_sa); wq_dq.push_back(a_dq); wq_ben.push_back(a_ben);
      end
      if (!a_oe_n && !a_we_n) clash++;
    end while (!a_ready && lat < 64);
    got_err = a_err;
    if (w && !got_err) ref_a[int'((adr - BASE) >> 2)] = merge32(get_a(int'((adr - BASE) >> 2)), wd, be);
  endtask

  task automatic run_b(input logic w, input logic [31:0] adr, input logic [63:0] wd);
    @(negedge clk);
    b_wr = w; b_rd = !w; b_adr = adr; b_wd = wd; b_be = 8'hFF;
    @(posedge clk); #1;
    b_wr = 1'b0; b_rd = 1'b0; b_wd = {$urandom, $urandom};
    lat = 0; we_cyc = 0; wq_addr.delete(); wq_dq.delete();
    do begin
      @(negedge clk); lat++;
      if (!b_we_n) begin we_cyc++; wq_addr.push_back(b_sa); wq_dq.push_back(b_dq); end
    end while (!b_ready && lat < 64);
    got_err = b_err;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    a_wr = 0; a_rd = 0; a_adr = 0; a_wd = 0; a_be = 0;
    b_wr = 0; b_rd = 0; b_adr = 0; b_wd = 0; b_be = 0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", a_ready); end
    n_checks++; if (a_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h exp 0", a_rdata); end
    n_checks++; if (a_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", a_err); end
    n_checks++; if ({a_we_n, a_ce_n, a_oe_n, a_ben} !== 5'b11111) begin
      n_fail++; $display("FAIL reset_strobes got %b exp 11111", {a_we_n, a_ce_n, a_oe_n, a_ben}); end
    n_checks++; if (a_sa !== 18'h0) begin n_fail++; $display("FAIL reset_addr got %h exp 0", a_sa); end
  endtask

  task automatic test_basic;
    logic [31:0] wd = 32'hDEADBEEF;
    run_a(1, 0, BASE, wd, 4'hF);
    n_checks++; if (lat !== LAT_WR_A || got_err !== 1'b0) begin
      n_fail++; $display("FAIL basic_wr_lat got %0d/err %b exp %0d/0", lat, got_err, LAT_WR_A); end
    n_checks++; if (we_cyc !== BEATS_A || clash !== 0) begin
      n_fail++; $display("FAIL basic_wr_beats got %0d clash %0d exp %0d", we_cyc, clash, BEATS_A); end
    for (int k = 0; k < BEATS_A && k < wq_addr.size(); k++) begin
      n_checks++;
      if (wq_addr[k] !== 18'(k) || wq_dq[k] !== wd[k*16 +: 16] || wq_ben[k] !== 2'b00) begin
        n_fail++; $display("FAIL basic_wr_beat%0d got a=%h d=%h be=%b exp a=%h d=%h be=00",
                           k, wq_addr[k], wq_dq[k], wq_ben[k], k, wd[k*16 +: 16]); end
    end
    run_a(0, 1, BASE, 0, 0);
    n_checks++; if (lat !== LAT_RD_A || ce_cyc !== BEATS_A + 1 || we_cyc !== 0) begin
      n_fail++; $display("FAIL basic_rd_timing got lat %0d ce %0d we %0d exp %0d %0d 0",
                         lat, ce_cyc, we_cyc, LAT_RD_A, BEATS_A + 1); end
    n_checks++; if (a_rdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL basic_rd_data got %h exp deadbeef", a_rdata); end
  endtask

  task automatic test_byte_lanes;
    run_a(1, 0, BASE + 4, 32'h11223344, 4'hF);
    run_a(1, 0, BASE + 4, 32'h0000AA00, 4'b0010);
    n_checks++; if (wq_ben.size() !== 2 || wq_ben[0] !== 2'b01 || wq_ben[1] !== 2'b11) begin
      n_fail++; $display("FAIL lanes_ben got %0d beats %b %b exp 01 11", wq_ben.size(), wq_ben[0], wq_ben[1]); end
    run_a(0, 1, BASE + 4, 0, 0);
    n_checks++; if (a_rdata !== 32'h1122AA44 || a_rdata !== get_a(1)) begin
      n_fail++; $display("FAIL lanes_rd got %h exp 1122aa44", a_rdata); end
    run_a(1, 0, BASE + 4, 32'h55667788, 4'h0);
    n_checks++; if (we_cyc !== BEATS_A || wq_ben[0] !== 2'b11 || wq_ben[1] !== 2'b11) begin
      n_fail++; $display("FAIL lanes_none got %0d beats exp %0d all 11", we_cyc, BEATS_A); end
  endtask

  task automatic test_wide;
    logic [63:0] wd = {$urandom, $urandom};
    run_b(1, BASE + 8, wd);
    n_checks++; if (lat !== LAT_WR_B || got_err !== 1'b0 || we_cyc !== BEATS_B) begin
      n_fail++; $display("FAIL wide_wr got lat %0d beats %0d exp %0d %0d", lat, we_cyc, LAT_WR_B, BEATS_B); end
    for (int k = 0; k < BEATS_B && k < wq_addr.size(); k++) begin
      n_checks++;
      if (wq_addr[k] !== 18'((8 / 8) * BEATS_B + k) || wq_dq[k] !== wd[k*16 +: 16]) begin
        n_fail++; $display("FAIL wide_beat%0d got a=%h d=%h exp a=%h d=%h", k, wq_addr[k], wq_dq[k],
                           (8 / 8) * BEATS_B + k, wd[k*16 +: 16]); end
    end
    run_b(0, BASE + 8, 0);
    n_checks++; if (lat !== LAT_RD_B || b_rdata !== wd) begin
      n_fail++; $display("FAIL wide_rd got lat %0d data %h exp %0d %h", lat, b_rdata, LAT_RD_B, wd); end
  endtask

  task automatic test_out_of_range;
    logic [31:0] prev = a_rdata;
    logic [31:0] last = BASE + ((1 << 17) - 1) * 4;
    run_a(0, 1, BASE - 4, 0, 0);
    n_checks++; if (lat !== 1 || got_err !== 1'b1 || ce_cyc !== 0 || a_rdata !== prev) begin
      n_fail++; $display("FAIL oor_low got lat %0d err %b ce %0d rd %h exp 1 1 0 %h", lat, got_err, ce_cyc, a_rdata, prev); end
    @(negedge clk);
    n_checks++; if (a_err !== 1'b0) begin n_fail++; $display("FAIL oor_pulse got %b exp 0", a_err); end
    run_a(1, 0, BASE + (1 << 19), 32'h12345678, 4'hF);
    n_checks++; if (lat !== 1 || got_err !== 1'b1 || ce_cyc !== 0 || we_cyc !== 0 || a_rdata !== prev) begin
      n_fail++; $display("FAIL oor_high got lat %0d err %b ce %0d we %0d exp 1 1 0 0", lat, got_err, ce_cyc, we_cyc); end
    run_a(1, 0, last, 32'hA5A55A5A, 4'hF);
    n_checks++; if (got_err !== 1'b0 || wq_addr.size() !== 2 || wq_addr[1] !== 18'h3FFFF) begin
      n_fail++; $display("FAIL oor_edge_wr got err %b addr %h exp 0 3ffff", got_err, wq_addr[1]); end
    run_a(0, 1, last, 0, 0);
    n_checks++; if (got_err !== 1'b0 || a_rdata !== 32'hA5A55A5A) begin
      n_fail++; $display("FAIL oor_edge_rd got err %b data %h exp 0 a5a55a5a", got_err, a_rdata); end
  endtask

  task automatic test_priority;
    run_a(1, 1, BASE, 32'hCAFEF00D, 4'hF);
    n_checks++; if (we_cyc !== BEATS_A || lat !== LAT_WR_A) begin
      n_fail++; $display("FAIL prio_wr got we %0d lat %0d exp %0d %0d", we_cyc, lat, BEATS_A, LAT_WR_A); end
    run_a(0, 1, BASE, 0, 0);
    n_checks++; if (a_rdata !== 32'hCAFEF00D) begin
      n_fail++; $display("FAIL prio_rd got %h exp cafef00d", a_rdata); end
  endtask

  task automatic test_random;
    for (int i = 0; i < 8; i++) run_a(1, 0, BASE + i * 4, $urandom, 4'hF);
    for (int n = 0; n < 30; n++) begin
      int idx = $urandom_range(0, 7);
      logic [31:0] adr = BASE + idx * 4 + $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) begin
        run_a(1, 0, adr, $urandom, 4'($urandom));
        n_checks++; if (lat !== LAT_WR_A || got_err !== 1'b0) begin
          n_fail++; $display("FAIL rand_wr%0d got lat %0d err %b exp %0d 0", n, lat, got_err, LAT_WR_A); end
      end else begin
        run_a(0, 1, adr, 0, 0);
        n_checks++; if (lat !== LAT_RD_A || a_rdata !== get_a(idx)) begin
          n_fail++; $display("FAIL rand_rd%0d got lat %0d data %h exp %0d %h", n, lat, a_rdata, LAT_RD_A, get_a(idx)); end
      end
    end
  endtask

  task automatic test_reset_mid_write;
    run_a(0, 1, BASE, 0, 0);
    @(negedge clk);
    a_wr = 1'b1; a_adr = BASE + 8; a_wd = 32'h0BADC0DE; a_be = 4'hF;
    @(posedge clk); #1; a_wr = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    n_checks++; if (a_we_n !== 1'b1 || a_ce_n !== 1'b1 || a_rdata !== 32'h0 || a_err !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid got we %b ce %b rd %h err %b exp 1 1 0 0", a_we_n, a_ce_n, a_rdata, a_err); end
    ref_a.delete(2);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    n_checks++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready got %b exp 1", a_ready); end
    run_a(0, 1, BASE + 4, 0, 0);
    n_checks++; if (lat !== LAT_RD_A || a_rdata !== get_a(1)) begin
      n_fail++; $display("FAIL rst_mid_rd got lat %0d data %h exp %0d %h", lat, a_rdata, LAT_RD_A, get_a(1)); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_byte_lanes;
    test_wide;
    test_out_of_range;
    test_priority;
    test_random;
    test_reset_mid_write;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached after %0d checks", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
